turn_sequencer: RTL and testbench
=================================

Name: turn_sequencer

Overview:
- Game-flow controller sitting directly upstream of check_win.
- Captures a player's card pick (5-bit tile number) on a button press and drives check_win's T/N/B inputs.
- Samples the resulting W (match) flag and decides whether the same player moves again or the turn passes.
- Keeps per-player scores, a pick timeout, and final winner/game-over outputs for the display logic.

Parameters:
- NUM_PLAYERS, 4, active players (2..4); turn index wraps at NUM_PLAYERS-1.
- TARGET_SCORE, 5, matches needed to win (1..7).
- B_PULSE, 2, cycles B is held high per commit (>=1).
- EVAL_WAIT, 3, cycles after B falls before W is sampled (>=1).
- TIMEOUT, 50_000_000, WAIT_PICK cycles before the turn is forfeited (0 disables).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  level from debounced switch; high leaves IDLE.
- btn  in  1  debounced pick button, asynchronous to game state.
- sel_n  in  5  card/tile number currently selected by the player.
- W  in  1  match flag from check_win.
- pos_data  in  5  afterposition_data from check_win; registered for display.
- T  out  2  current player index to check_win.
- N  out  5  committed card number to check_win.
- B  out  1  commit strobe to check_win.
- scores  out  12  packed 3-bit score per player, player0 in [2:0].
- last_pos  out  5  pos_data captured at evaluation.
- game_over  out  1  high in DONE.
- winner  out  2  player index that reached TARGET_SCORE; valid when game_over=1.
- phase  out  3  FSM state encoding, for the LED/7-seg driver.

Behaviour:
- Reset (rst=0, async): state IDLE; T=0, N=0, B=0, scores=0, last_pos=0, game_over=0, winner=0, all counters 0, button sync regs 0.
- btn handling: 2-flop synchroniser, then rising-edge detect giving a one-cycle press. A held button yields exactly one press.
- IDLE: all outputs at reset values. start=1 -> WAIT_PICK next cycle.
- WAIT_PICK:
  - Timeout counter increments each cycle.
  - A press latches N<=sel_n, clears the counter, goes to COMMIT.
  - If the counter reaches TIMEOUT-1 with no press (TIMEOUT>0), go to PASS; B is not pulsed.
  - If a press and the timeout hit occur in the same cycle, the press wins.
- COMMIT: B=1 for exactly B_PULSE cycles. N and T are stable throughout and for the whole of EVAL. Then go to EVAL.
- EVAL: B=0. Wait EVAL_WAIT cycles. On the final cycle sample W and pos_data:
  - last_pos<=pos_data.
  - If W=1: score[T]+=1. If the new score equals TARGET_SCORE: winner<=T, go to DONE. Otherwise return to WAIT_PICK with the same T.
  - If W=0: go to PASS.
- PASS: one cycle. T<=(T==NUM_PLAYERS-1) ? 0 : T+1. Go to WAIT_PICK.
- DONE: game_over=1. Hold all outputs and ignore btn/start until rst.
- Presses during COMMIT, EVAL or PASS are discarded; they are not queued.
- Scores saturate at TARGET_SCORE and never wrap. Unused player slots (index >= NUM_PLAYERS) stay 0.
- start dropping mid-game has no effect; only rst returns to IDLE. rst asserted mid-COMMIT drops B immediately (async).
- Latency: press edge at pin to B high = 4 cycles (2 sync + edge + state).
- phase encoding: IDLE=0, WAIT_PICK=1, COMMIT=2, EVAL=3, PASS=4, DONE=5.

Decomposition:
- Shared package game_pkg:
  - state enum / phase encodings;
  - PLAYER_W=2, POS_W=5, SCORE_W=3;
  - default NUM_PLAYERS and TARGET_SCORE.
- One sub-module: btn_edge_sync (2-flop sync + rising-edge pulse, async active-low reset). It is reusable by the other button consumers on the board.

Test Plan:
- Reset and idle: rst low mid-run, then high with start=0 for 20 cycles -> T=0, B=0, scores=0, phase=0; start=1 -> phase=1 next cycle.
- Match path: sel_n=7, press, W model returns 1 -> B high exactly B_PULSE cycles, 4 cycles after the press edge; N=7 throughout; score0=1; T stays 0; phase back to 1.
- Miss path: press with W=0 -> score unchanged; T 0->1. Repeat misses for players 1,2,3 -> T wraps to 0. With NUM_PLAYERS=3, T wraps after 2.
- Timeout: TIMEOUT=10, no press -> PASS after 10 WAIT_PICK cycles with no B pulse; T increments. A press on the last cycle -> COMMIT, not PASS.
- Win and hold: player 2 gets 5 consecutive W=1 -> game_over=1, winner=2, scores[8:6]=5; further presses produce no B and scores hold until rst.
- Button robustness: btn held high 100 cycles -> exactly one B burst. Presses during EVAL are ignored, and no extra commit follows.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared widths, phase encodings and helpers for the game-flow logic
package game_pkg;
  localparam int PLAYER_W = 2;
  localparam int POS_W = 5;
  localparam int CARD_W = 5;
  localparam int SCORE_W = 3;
  localparam int MAX_PLAYERS = 4;
  localparam int DEF_NUM_PLAYERS = 4;
  localparam int DEF_TARGET_SCORE = 5;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PICK = 3'd1,
    COMMIT    = 3'd2,
    EVAL      = 3'd3,
    PASS      = 3'd4,
    DONE      = 3'd5
  } state_e;
  function automatic logic [PLAYER_W-1:0] next_player(input logic [PLAYER_W-1:0] t, input int np);
    return (t == PLAYER_W'(np - 1)) ? '0 : t + 1'b1;
  endfunction
endpackage

// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: T/N/B commit bundle towards check_win and its W/pos_data reply
interface turn_sequencer_if;
  import game_pkg::*;
  logic [PLAYER_W-1:0] T;
  logic [CARD_W-1:0] N;
  logic B;
  logic W;
  logic [POS_W-1:0] pos_data;
  modport master(output T, N, B, input W, pos_data);
  modport slave(input T, N, B, output W, pos_data);
endinterface

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: 2-flop synchroniser plus registered one-cycle rising-edge pulse
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic s1_q, s2_q, prev_q, press_q, press_d;
  always_comb press_d = s2_q & ~prev_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1_q, s2_q, prev_q, press_q} <= '0;
    else {s1_q, s2_q, prev_q, press_q} <= {btn, s1_q, s2_q, press_d};
  assign press = press_q;
endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: captures card picks, strobes check_win, scores matches and rotates turns
module turn_sequencer
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS,
  parameter int TARGET_SCORE = DEF_TARGET_SCORE,
  parameter int B_PULSE      = 2,
  parameter int EVAL_WAIT    = 3,
  parameter int TIMEOUT      = 50_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             btn,
  input  logic [CARD_W-1:0]                sel_n,
  turn_sequencer_if.master                 cw,
  output logic [MAX_PLAYERS*SCORE_W-1:0]   scores,
  output logic [POS_W-1:0]                 last_pos,
  output logic                             game_over,
  output logic [PLAYER_W-1:0]              winner,
  output logic [2:0]                       phase
);
  localparam int CMAX = (TIMEOUT > B_PULSE + EVAL_WAIT) ? TIMEOUT : B_PULSE + EVAL_WAIT;
  localparam int CW = $clog2(CMAX + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PLAYER_W-1:0] t_q, t_d, winner_q, winner_d;
  logic [CARD_W-1:0] n_q, n_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [MAX_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] cur, inc;
  logic press, to_hit;
  btn_edge_sync u_btn (.clk(clk), .rst(rst), .btn(btn), .press(press));
  assign cur = score_q[t_q];
  assign inc = (cur == SCORE_W'(TARGET_SCORE)) ? cur : cur + 1'b1;
  assign to_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
  // cnt_q is shared: pick timeout, B pulse width and evaluation wait
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    t_d = t_q;
    n_d = n_q;
    pos_d = pos_q;
    score_d = score_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: state_d = start ? WAIT_PICK : IDLE;
      WAIT_PICK: begin
        cnt_d = cnt_q + 1'b1;
        if (press) begin
          n_d = sel_n;
          cnt_d = '0;
          state_d = COMMIT;
        end else if (to_hit) begin
          cnt_d = '0;
          state_d = PASS;
        end
      end
      COMMIT: begin
        cnt_d = (cnt_q == CW'(B_PULSE - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(B_PULSE - 1)) ? EVAL : COMMIT;
      end
      EVAL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(EVAL_WAIT - 1)) begin
          cnt_d = '0;
          pos_d = cw.pos_data;
          state_d = PASS;
          if (cw.W) begin
            score_d[t_q] = inc;
            winner_d = (inc == SCORE_W'(TARGET_SCORE)) ? t_q : winner_q;
            state_d = (inc == SCORE_W'(TARGET_SCORE)) ? DONE : WAIT_PICK;
          end
        end
      end
      PASS: begin
        t_d = next_player(t_q, NUM_PLAYERS);
        state_d = WAIT_PICK;
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      t_q <= '0;
      n_q <= '0;
      pos_q <= '0;
      score_q <= '0;
      winner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      t_q <= t_d;
      n_q <= n_d;
      pos_q <= pos_d;
      score_q <= score_d;
      winner_q <= winner_d;
    end
  assign cw.T = t_q;
  assign cw.N = n_q;
  assign cw.B = (state_q == COMMIT);
  assign scores = score_q;
  assign last_pos = pos_q;
  assign game_over = (state_q == DONE);
  assign winner = winner_q;
  assign phase = state_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed picks with a commit scoreboard checked on every B burst
module tb_turn_sequencer;
  import game_pkg::*;
  localparam int NP = 4, TS = 5, BP = 2, EW = 3, TO = 10;
  logic clk = 0, rst = 0, start = 0, btn = 0;
  logic [4:0] sel_n = 0;
  logic [11:0] scores;
  logic [4:0] last_pos;
  logic game_over;
  logic [1:0] winner;
  logic [2:0] phase;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [1:0] t; logic [4:0] n;} exp_t;
  exp_t exp_q[$];
  exp_t cur_e;
  bit b_prev = 0;
  int blen = 0;
  int t_m;
  logic [2:0] sc_m [4];
  logic [4:0] lp_m;
  bit done_m;
  turn_sequencer_if cw();
  turn_sequencer #(.NUM_PLAYERS(NP), .TARGET_SCORE(TS), .B_PULSE(BP), .EVAL_WAIT(EW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .sel_n(sel_n), .cw(cw),
    .scores(scores), .last_pos(last_pos), .game_over(game_over), .winner(winner), .phase(phase)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] pk();
    return {sc_m[3], sc_m[2], sc_m[1], sc_m[0]};
  endfunction
  task automatic clr_model();
    t_m = 0;
    foreach (sc_m[i]) sc_m[i] = 0;
    lp_m = 0;
    done_m = 0;
  endtask
  task automatic begin_pick(input logic [4:0] n, input logic w);
    sel_n = n;
    cw.W = w;
    cw.pos_data = n ^ 5'h15;
    exp_q.push_back('{t: 2'(t_m), n: n});
    btn = 1;
  endtask
  task automatic finish_pick(input logic w);
    int k;
    sel_n = ~sel_n;
    k = 0;
    while (phase != 3'd3 && k < 30) begin tick(1); k++; end
    if (k == 30) begin n_cmp++; n_bad++; $display("FAIL eval_wait: phase %0d, required 3 within 30 cycles", phase); end
    k = 0;
    while (phase == 3'd3 && k < 30) begin tick(1); k++; end
    if (k == 30) begin n_cmp++; n_bad++; $display("FAIL eval_exit: phase 3 still, required exit within 30 cycles"); end
    if (phase == 3'd4) tick(1);
    lp_m = cw.pos_data;
    if (w) begin
      sc_m[t_m] = sc_m[t_m] + 3'd1;
      done_m = (sc_m[t_m] == 3'(TS));
    end else t_m = (t_m == NP - 1) ? 0 : t_m + 1;
    chk("phase_after", phase, done_m ? 5 : 1);
    chk("T_after", cw.T, t_m);
    chk("scores_after", scores, pk());
    chk("last_pos", last_pos, lp_m);
    if (done_m) begin
      chk("game_over", game_over, 1);
      chk("winner", winner, t_m);
    end
  endtask
  task automatic pick(input logic [4:0] n, input logic w);
    begin_pick(n, w);
    tick(4);
    btn = 0;
    finish_pick(w);
  endtask
  task automatic chk_reset();
    chk("rst_phase", phase, 0);
    chk("rst_T", cw.T, 0);
    chk("rst_B", cw.B, 0);
    chk("rst_N", cw.N, 0);
    chk("rst_scores", scores, 0);
    chk("rst_last_pos", last_pos, 0);
    chk("rst_game_over", game_over, 0);
  endtask
  // scoreboard monitor: every B burst must match a pending commit and last BP cycles
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        b_prev = 0;
        blen = 0;
      end else if (cw.B) begin
        if (!b_prev) begin
          blen = 0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_B: B=1 with no commit pending, required 0");
            cur_e = '{t: cw.T, n: cw.N};
          end else cur_e = exp_q.pop_front();
        end
        blen++;
        chk("commit_T", cw.T, cur_e.t);
        chk("commit_N", cw.N, cur_e.n);
        b_prev = 1;
      end else begin
        if (b_prev) chk("B_len", blen, BP);
        b_prev = 0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cw.W = 0;
    cw.pos_data = 0;
    clr_model();
    tick(3);
    chk_reset();
    rst = 1;
    tick(20);
    chk_reset();
    start = 1;
    tick(1);
    chk("start_phase", phase, 1);
    begin_pick(5'd7, 1);
    tick(3);
    chk("B_lat3", cw.B, 0);
    tick(1);
    chk("B_lat4", cw.B, 1);
    btn = 0;
    finish_pick(1);
    pick(5'd3, 0);
    pick(5'd9, 0);
    pick(5'd12, 0);
    pick(5'd30, 0);
    tick(9);
    chk("to_wait", phase, 1);
    tick(1);
    chk("to_pass", phase, 4);
    tick(1);
    t_m = (t_m == NP - 1) ? 0 : t_m + 1;
    chk("to_back", phase, 1);
    chk("to_T", cw.T, t_m);
    tick(6);
    begin_pick(5'd17, 0);
    tick(3);
    chk("to_last_wait", phase, 1);
    tick(1);
    chk("to_last_commit", phase, 2);
    btn = 0;
    finish_pick(0);
    begin_pick(5'd11, 1);
    tick(2);
    btn = 0;
    tick(2);
    btn = 1;
    tick(2);
    btn = 0;
    finish_pick(1);
    begin_pick(5'd21, 0);
    tick(100);
    btn = 0;
    tick(2);
    chk("hold_q_empty", exp_q.size(), 0);
    start = 0;
    rst = 0;
    tick(2);
    chk_reset();
    rst = 1;
    tick(20);
    chk_reset();
    clr_model();
    start = 1;
    tick(1);
    chk("restart_phase", phase, 1);
    begin_pick(5'd13, 1);
    tick(4);
    chk("arst_B_before", cw.B, 1);
    @(negedge clk);
    #2 rst = 0;
    #1 chk("arst_B_drop", cw.B, 0);
    chk("arst_phase", phase, 0);
    btn = 0;
    tick(2);
    rst = 1;
    clr_model();
    tick(1);
    chk("arst_restart", phase, 1);
    pick(5'd1, 0);
    pick(5'd2, 0);
    for (int i = 0; i < 5; i++) pick(5'(20 + i), 1);
    chk("win_scores", scores, 12'h140);
    btn = 1;
    tick(6);
    btn = 0;
    tick(10);
    chk("done_phase", phase, 5);
    chk("done_scores", scores, 12'h140);
    chk("done_winner", winner, 2);
    chk("done_B", cw.B, 0);
    chk("done_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
